// File: rtl/dilithium_poly_unpack_if.sv
// Bundle of the control, packed-input and coefficient-output handshakes of
// dilithium_poly_unpack.
interface dilithium_poly_unpack_if #(
    parameter int unsigned W       = 64,
    parameter int unsigned LANES   = 4,
    parameter int unsigned COEFF_W = 23
);
    logic                     start;
    logic [2:0]               sec_lvl;
    logic [2:0]               mode;
    logic                     busy;
    logic                     err;
    logic [W-1:0]             di;
    logic                     di_valid;
    logic                     di_ready;
    logic [LANES*COEFF_W-1:0] samples;
    logic                     s_valid;
    logic                     s_ready;
    logic                     s_last;

    modport master (
        output start, sec_lvl, mode, di, di_valid, s_ready,
        input  busy, err, di_ready, samples, s_valid, s_last
    );

    modport slave (
        input  start, sec_lvl, mode, di, di_valid, s_ready,
        output busy, err, di_ready, samples, s_valid, s_last
    );
endinterface

// File: rtl/dilithium_poly_unpack.sv
// Unpacks one 256-coefficient Dilithium polynomial per start from a W-bit LSB-first
// bitstream into LANES coefficients per beat, each mapped into [0, Q).
module dilithium_poly_unpack #(
    parameter int unsigned W       = 64,
    parameter int unsigned LANES   = 4,
    parameter int unsigned COEFF_W = 23
) (
    input logic                    clk,
    input logic                    rst,
    dilithium_poly_unpack_if.slave bus
);
    localparam int unsigned MaxB  = 20;
    localparam int unsigned BufW  = LANES * MaxB + W;
    localparam int unsigned FillW = $clog2(BufW + 1);
    // Covers 256*20/16 = 320 input words and 256 beats.
    localparam int unsigned CntW  = 10;
    localparam int unsigned WLog  = $clog2(W);
    localparam int unsigned Beats = 256 / LANES;
    localparam logic [COEFF_W:0] QMod = (COEFF_W + 1)'(8380417);

    typedef enum logic {StIdle, StRun} state_e;
    typedef enum logic [2:0] {KindT0, KindT1, KindEta, KindW1, KindZ} kind_e;

    state_e                   state_q;
    kind_e                    kind_q;
    logic [4:0]               b_q;
    logic [19:0]              off_q;
    logic [FillW-1:0]         step_q;
    logic [CntW-1:0]          target_q;
    logic [CntW-1:0]          words_q;
    logic [CntW-1:0]          beats_q;
    logic [BufW-1:0]          buf_q;
    logic [FillW-1:0]         fill_q;
    logic [LANES*COEFF_W-1:0] samples_q;
    logic                     s_valid_q;
    logic                     s_last_q;
    logic                     err_q;

    logic                     legal;
    kind_e                    dec_kind;
    logic [4:0]               dec_b;
    logic [19:0]              dec_off;
    logic [FillW-1:0]         dec_step;
    logic [CntW-1:0]          dec_target;

    logic                     di_ready;
    logic                     accept;
    logic                     extract;
    logic                     drain;
    logic [BufW-1:0]          buf_base;
    logic [BufW-1:0]          buf_next;
    logic [FillW-1:0]         fill_base;
    logic [FillW-1:0]         fill_next;
    logic [19:0]              mask;
    logic [19:0]              field;
    logic [LANES*COEFF_W-1:0] mapped;

    // Offset-minus-field with modular wrap covers T0, eta and gamma formats alike.
    function automatic logic [COEFF_W-1:0] map_coeff(input logic [19:0] x, input kind_e kind,
                                                     input logic [19:0] off);
        logic [COEFF_W:0] xe;
        logic [COEFF_W:0] oe;
        logic [COEFF_W:0] r;
        xe = (COEFF_W + 1)'(x);
        oe = (COEFF_W + 1)'(off);
        case (kind)
            KindT1:  r = xe << 13;
            KindW1:  r = xe;
            default: r = (xe > oe) ? (oe + QMod - xe) : (oe - xe);
        endcase
        return r[COEFF_W-1:0];
    endfunction

    always_comb begin
        legal    = ((bus.sec_lvl == 3'd2) || (bus.sec_lvl == 3'd3) || (bus.sec_lvl == 3'd5))
                   && (bus.mode <= 3'd5);
        dec_kind = KindT0;
        dec_b    = 5'd13;
        dec_off  = 20'd4096;
        case (bus.mode)
            3'd1: begin
                dec_kind = KindT1;
                dec_b    = 5'd10;
                dec_off  = 20'd0;
            end
            3'd2, 3'd3: begin
                dec_kind = KindEta;
                dec_b    = (bus.sec_lvl == 3'd3) ? 5'd4 : 5'd3;
                dec_off  = (bus.sec_lvl == 3'd3) ? 20'd4 : 20'd2;
            end
            3'd4: begin
                dec_kind = KindW1;
                dec_b    = (bus.sec_lvl == 3'd2) ? 5'd6 : 5'd4;
                dec_off  = 20'd0;
            end
            3'd5: begin
                dec_kind = KindZ;
                dec_b    = (bus.sec_lvl == 3'd2) ? 5'd18 : 5'd20;
                dec_off  = (bus.sec_lvl == 3'd2) ? 20'h20000 : 20'h80000;
            end
            default: ;
        endcase
        dec_step   = FillW'(LANES * 32'(dec_b));
        dec_target = CntW'((32'(dec_b) << 8) >> WLog);
    end

    // di_ready looks only at registered state so s_ready never reaches it.
    assign di_ready = (state_q == StRun) && (words_q < target_q)
                      && (({1'b0, fill_q} + (FillW + 1)'(W)) <= (FillW + 1)'(BufW));
    assign accept   = bus.di_valid && di_ready;
    assign drain    = s_valid_q && bus.s_ready;
    assign extract  = (state_q == StRun) && (fill_q >= step_q) && (!s_valid_q || bus.s_ready);

    // Bits at and above fill are always zero, so a plain OR appends the new word.
    always_comb begin
        buf_base  = extract ? (buf_q >> step_q) : buf_q;
        fill_base = extract ? (fill_q - step_q) : fill_q;
        buf_next  = buf_base;
        fill_next = fill_base;
        if (accept) begin
            buf_next  = buf_base | (BufW'(bus.di) << fill_base);
            fill_next = fill_base + FillW'(W);
        end
    end

    always_comb begin
        mask   = (20'd1 << b_q) - 20'd1;
        field  = '0;
        mapped = '0;
        for (int i = 0; i < LANES; i++) begin
            field = 20'(buf_q >> (i * int'(b_q))) & mask;
            mapped[i*COEFF_W +: COEFF_W] = map_coeff(field, kind_q, off_q);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            kind_q    <= KindT0;
            b_q       <= '0;
            off_q     <= '0;
            step_q    <= '0;
            target_q  <= '0;
            words_q   <= '0;
            beats_q   <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
            samples_q <= '0;
            s_valid_q <= 1'b0;
            s_last_q  <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            err_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        if (legal) begin
                            state_q  <= StRun;
                            kind_q   <= dec_kind;
                            b_q      <= dec_b;
                            off_q    <= dec_off;
                            step_q   <= dec_step;
                            target_q <= dec_target;
                            words_q  <= '0;
                            beats_q  <= '0;
                            buf_q    <= '0;
                            fill_q   <= '0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StRun: begin
                    buf_q  <= buf_next;
                    fill_q <= fill_next;
                    if (accept) begin
                        words_q <= words_q + CntW'(1);
                    end
                    if (extract) begin
                        samples_q <= mapped;
                        s_valid_q <= 1'b1;
                        s_last_q  <= (beats_q == CntW'(Beats - 1));
                        beats_q   <= beats_q + CntW'(1);
                    end else if (drain) begin
                        s_valid_q <= 1'b0;
                        s_last_q  <= 1'b0;
                        if (s_last_q) begin
                            state_q <= StIdle;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.busy     = (state_q == StRun);
    assign bus.err      = err_q;
    assign bus.di_ready = di_ready;
    assign bus.samples  = samples_q;
    assign bus.s_valid  = s_valid_q;
    assign bus.s_last   = s_last_q;
endmodule

// File: tb/tb_dilithium_poly_unpack.sv
// Randomised bench for dilithium_poly_unpack: coefficients are predicted from the
// field values and the format rules, then compared beat by beat.
module tb_dilithium_poly_unpack;
    localparam int W         = 64;
    localparam int LANES     = 4;
    localparam int COEFF_W   = 23;
    localparam int Q         = 8380417;
    localparam int BEATS     = 256 / LANES;
    localparam int BudgetCyc = 4000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    dilithium_poly_unpack_if #(.W(W), .LANES(LANES), .COEFF_W(COEFF_W)) bus ();

    dilithium_poly_unpack #(.W(W), .LANES(LANES), .COEFF_W(COEFF_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    int exp_q[$];
    int beats_seen = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int field_bits(input int sec, input int md);
        case (md)
            0:       return 13;
            1:       return 10;
            2, 3:    return (sec == 3) ? 4 : 3;
            4:       return (sec == 2) ? 6 : 4;
            default: return (sec == 2) ? 18 : 20;
        endcase
    endfunction

    function automatic int ref_map(input int sec, input int md, input int x);
        int eta;
        int gamma;
        case (md)
            0: return (x > 4096) ? Q - x + 4096 : 4096 - x;
            1: return x * 8192;
            2, 3: begin
                eta = (sec == 3) ? 4 : 2;
                return (x > eta) ? Q - x + eta : eta - x;
            end
            4: return x;
            default: begin
                gamma = (sec == 2) ? (1 << 17) : (1 << 19);
                return (x > gamma) ? gamma + Q - x : gamma - x;
            end
        endcase
    endfunction

    // Output monitor: every accepted beat against the predicted queue, held beats for stability.
    initial begin
        logic [LANES*COEFF_W-1:0] hold_samples;
        bit hold_prev;
        int e;
        hold_prev = 1'b0;
        hold_samples = '0;
        forever begin
            @(negedge clk);
            if (rst || !bus.s_valid) begin
                hold_prev = 1'b0;
            end else if (!bus.s_ready) begin
                if (hold_prev) check("hold_stable", longint'(bus.samples == hold_samples), 1);
                hold_samples = bus.samples;
                hold_prev = 1'b1;
            end else begin
                hold_prev = 1'b0;
                if (exp_q.size() < LANES) begin
                    check("extra_beat", exp_q.size(), LANES);
                end else begin
                    check("s_last", bus.s_last, longint'(exp_q.size() == LANES));
                    for (int i = 0; i < LANES; i++) begin
                        e = exp_q.pop_front();
                        check("lane", bus.samples[i*COEFF_W +: COEFF_W], e);
                    end
                    beats_seen++;
                end
            end
        end
    end

    task automatic run_poly(input int sec, input int md, input int fields[256],
                            input int stall_pct, input int bp_pct, input int hold_at,
                            input bit mid_start);
        bit bits[256*20];
        logic [W-1:0] words[$];
        logic [W-1:0] wd;
        int b;
        int nwords;
        int idx;
        int c1;
        int c2;
        bit rdy;
        bit held;
        b = field_bits(sec, md);
        nwords = 256 * b / W;
        for (int k = 0; k < 256; k++) begin
            for (int j = 0; j < b; j++) bits[k*b+j] = bit'((fields[k] >> j) & 1);
            exp_q.push_back(ref_map(sec, md, fields[k]));
        end
        for (int n = 0; n < nwords; n++) begin
            for (int j = 0; j < W; j++) wd[j] = bits[n*W+j];
            words.push_back(wd);
        end
        beats_seen = 0;
        held = 1'b0;
        idx = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.sec_lvl = 3'(sec);
        bus.mode = 3'(md);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("busy_after_start", bus.busy, 1);
        check("di_ready_after_start", bus.di_ready, 1);
        fork
            begin
                c1 = 0;
                while (idx < nwords && c1 < BudgetCyc) begin
                    @(posedge clk); #1;
                    bus.di = words[idx];
                    bus.di_valid = (int'($urandom_range(99)) >= stall_pct);
                    @(negedge clk);
                    rdy = bus.di_ready;
                    if (bus.di_valid && rdy) idx++;
                    c1++;
                end
                @(posedge clk); #1;
                bus.di_valid = 1'b0;
                @(negedge clk);
                check("di_ready_after_target", bus.di_ready, 0);
            end
            begin
                c2 = 0;
                while (beats_seen < BEATS && c2 < BudgetCyc) begin
                    @(posedge clk); #1;
                    if (hold_at >= 0 && beats_seen == hold_at && !held) begin
                        bus.s_ready = 1'b0;
                        repeat (9) begin
                            @(posedge clk); #1;
                        end
                        @(negedge clk);
                        if (idx < nwords) check("di_ready_backpressure", bus.di_ready, 0);
                        held = 1'b1;
                    end else begin
                        bus.s_ready = (int'($urandom_range(99)) >= bp_pct);
                    end
                    c2++;
                end
            end
            begin
                if (mid_start) begin
                    repeat (3) @(posedge clk);
                    #1;
                    bus.start = 1'b1;
                    bus.sec_lvl = 3'd4;
                    @(posedge clk); #1;
                    bus.start = 1'b0;
                    bus.sec_lvl = 3'(sec);
                    @(negedge clk);
                    check("err_while_busy", bus.err, 0);
                    @(negedge clk);
                    check("err_while_busy_2", bus.err, 0);
                end
            end
        join
        check("beat_count", beats_seen, BEATS);
        check("word_count", idx, nwords);
        @(negedge clk);
        check("busy_done", bus.busy, 0);
        check("s_valid_done", bus.s_valid, 0);
        check("exp_left", exp_q.size(), 0);
        exp_q.delete();
        bus.s_ready = 1'b1;
    endtask

    task automatic illegal_start(input int sec, input int md);
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.sec_lvl = 3'(sec);
        bus.mode = 3'(md);
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(negedge clk);
        check("err_pulse", bus.err, 1);
        check("err_busy", bus.busy, 0);
        @(negedge clk);
        check("err_one_cycle", bus.err, 0);
        check("err_busy_2", bus.busy, 0);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int f[256];
        int secs[3];
        int sec;
        int md;
        int b;
        secs = '{2, 3, 5};
        bus.start = 1'b0;
        bus.sec_lvl = 3'd2;
        bus.mode = 3'd0;
        bus.di = '0;
        bus.di_valid = 1'b0;
        bus.s_ready = 1'b1;

        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_err", bus.err, 0);
        check("rst_di_ready", bus.di_ready, 0);
        check("rst_s_valid", bus.s_valid, 0);
        check("rst_s_last", bus.s_last, 0);
        check("rst_samples", longint'(bus.samples == '0), 1);
        @(posedge clk); #1;
        rst = 1'b0;

        check("model_t1", ref_map(2, 1, 1023), 8380416);
        check("model_t0_4097", ref_map(3, 0, 4097), 8380416);
        check("model_t0_4096", ref_map(3, 0, 4096), 0);
        check("model_s1_sec2", ref_map(2, 2, 3), 8380416);
        check("model_s1_sec3", ref_map(3, 2, 8), 8380413);
        check("model_z_gamma", ref_map(3, 5, 524289), 8380416);
        check("model_w1", ref_map(2, 4, 43), 43);

        for (int k = 0; k < 256; k++) f[k] = 1023;
        run_poly(2, 1, f, 0, 0, -1, 1'b1);

        for (int k = 0; k < 256; k++) f[k] = (k % 2 == 1) ? 4097 : 0;
        f[100] = 4096;
        run_poly(3, 0, f, 0, 0, -1, 1'b0);

        for (int k = 0; k < 256; k++) f[k] = int'($urandom_range(7));
        f[0] = 0;
        f[1] = 3;
        run_poly(2, 2, f, 10, 10, -1, 1'b0);

        for (int k = 0; k < 256; k++) f[k] = int'($urandom_range(15));
        f[0] = 8;
        run_poly(3, 2, f, 10, 10, -1, 1'b0);

        for (int k = 0; k < 256; k++) f[k] = int'($urandom_range(20'hFFFFF));
        f[0] = 0;
        f[1] = 524289;
        f[2] = 524288;
        run_poly(3, 5, f, 30, 30, -1, 1'b0);

        for (int k = 0; k < 256; k++) f[k] = int'($urandom_range(63));
        f[0] = 43;
        run_poly(2, 4, f, 0, 20, -1, 1'b0);

        for (int k = 0; k < 256; k++) f[k] = int'($urandom_range(8191));
        run_poly(3, 0, f, 0, 0, 5, 1'b0);

        for (int r = 0; r < 6; r++) begin
            sec = secs[$urandom_range(2)];
            md = int'($urandom_range(5));
            b = field_bits(sec, md);
            for (int k = 0; k < 256; k++) f[k] = int'($urandom_range((1 << b) - 1));
            run_poly(sec, md, f, int'($urandom_range(40)), int'($urandom_range(40)), -1, 1'b0);
        end

        illegal_start(4, 1);
        illegal_start(2, 6);

        // Abort mid-polynomial with the output stalled, then a clean restart.
        bus.s_ready = 1'b0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        bus.sec_lvl = 3'd2;
        bus.mode = 3'd1;
        @(posedge clk); #1;
        bus.start = 1'b0;
        bus.di = '1;
        bus.di_valid = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_s_valid", bus.s_valid, 0);
        check("abort_di_ready", bus.di_ready, 0);
        check("abort_s_last", bus.s_last, 0);
        check("abort_samples", longint'(bus.samples == '0), 1);
        bus.di_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        exp_q.delete();
        bus.s_ready = 1'b1;
        for (int k = 0; k < 256; k++) f[k] = 1023;
        run_poly(2, 1, f, 0, 0, -1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
